// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: canonical NOP, PC increment and the
// {insn, pc} entry carried through the prefetch buffer.
package riscv_pkg;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous prefetch FIFO. Flush empties it and wins over a push
// arriving in the same cycle. A push into a full FIFO is only accepted
// when a pop frees a slot in the same cycle.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage updates for push/pop/flush.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: issues sequential word fetches on an in-order
// req/gnt/rvalid bus, buffers returned words in ifu_fifo and presents one
// registered IR/PC per cycle to decode. Redirects flush the pipe and drop
// responses still in flight for the old path.
// Optional macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt.
module ifu_fetch
  import riscv_pkg::*;
#(
  parameter int                 INS_WIDTH  = 32,
  parameter int                 PC_WIDTH   = 32,
  parameter int                 FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [INS_WIDTH-1:0] imem_rdata,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [INS_WIDTH-1:0] IR,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 ifu_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam int                    CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int                    ENT_W      = INS_WIDTH + PC_WIDTH;
  localparam logic [INS_WIDTH-1:0]  NOP        = INS_WIDTH'(INSN_NOP);
  localparam logic [PC_WIDTH-1:0]   STEP       = PC_WIDTH'(PC_STEP);
  localparam logic [CNT_W:0]        CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [INS_WIDTH-1:0] ir_q, ir_d;
  logic                 ifu_valid_q, ifu_valid_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 unused_fifo_full;
  logic [ENT_W-1:0]     fifo_head;
  logic [CNT_W:0]       credit_used;
  logic                 issue, rsp_accept, rsp_drop, fifo_push, fifo_pop;
  logic [PC_WIDTH-1:0]  redirect_target;
  logic                 unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Bus handshake, credit check and response classification for this cycle.
  always_comb begin
    credit_used     = {1'b0, fifo_count} + {1'b0, outstanding_q};
    imem_req        = resetn && !redirect_valid && (credit_used < CREDIT_MAX);
    imem_addr       = fetch_pc_q;
    issue           = imem_req && imem_gnt;
    rsp_accept      = imem_rvalid && (outstanding_q != '0);
    rsp_drop        = rsp_accept && (drop_cnt_q != '0);
    fifo_push       = rsp_accept && !rsp_drop;
    fifo_pop        = !redirect_valid && !stall && !fifo_empty;
    redirect_target = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  end

  // Fetch address, in-flight accounting and the PC owed to the next kept response.
  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_accept);
    drop_cnt_d    = drop_cnt_q - CNT_W'(rsp_drop);
    fetch_pc_d    = issue ? fetch_pc_q + STEP : fetch_pc_q;
    rsp_pc_d      = fifo_push ? rsp_pc_q + STEP : rsp_pc_q;
    if (redirect_valid) begin
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
    end
  end

  // Decode-facing register: redirect bubble, stall hold, pop, or idle bubble.
  always_comb begin
    ir_d        = ir_q;
    pc_d        = pc_q;
    ifu_valid_d = ifu_valid_q;
    if (redirect_valid) begin
      ir_d        = NOP;
      ifu_valid_d = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        ir_d        = fifo_head[ENT_W-1:PC_WIDTH];
        pc_d        = fifo_head[PC_WIDTH-1:0];
        ifu_valid_d = 1'b1;
      end else begin
        ir_d        = NOP;
        ifu_valid_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      pc_q          <= '0;
      ir_q          <= NOP;
      ifu_valid_q   <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ifu_valid_q   <= ifu_valid_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign IR        = ir_q;
  assign PC        = pc_q;
  assign ifu_valid = ifu_valid_q;

  ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data ({imem_rdata, rsp_pc_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (unused_fifo_full)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Count instructions accepted by decode and redirect cycles.
  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(ifu_valid_q && !stall);
    perf_flush_d = perf_flush_q + 32'(redirect_valid);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
